// File: rtl/keypad_scanner.sv
// keypad_scanner: round-robin 4x4 hex keypad row scanner with press/release debounce
// and single-key lockout. Define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DWELL_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

  if (SCAN_CYCLES < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("keypad_scanner: SCAN_CYCLES>=4, DEBOUNCE_CYCLES>=2, REPEAT_CYCLES>=2 required");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         row_idx, row_nxt;
  logic [1:0]         col_idx, col_nxt;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic [DEB_W-1:0]   deb_cnt, deb_nxt;
  logic [3:0]         key_nxt;
  logic               valid_nxt;
  logic               held_nxt;
  logic               col_high;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt, rep_nxt;
`endif

  // Lowest-index active-low column wins when several are down on one row.
  function automatic logic [1:0] first_low(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!c[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign col_high = cols[col_idx];

  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    col_nxt   = col_idx;
    dwell_nxt = dwell;
    deb_nxt   = deb_cnt;
    key_nxt   = key;
    valid_nxt = 1'b0;
    held_nxt  = key_held;
`ifdef KEYPAD_REPEAT_EN
    rep_nxt   = rep_cnt;
`endif
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (cols != 4'hF) begin
            col_nxt   = first_low(cols);
            deb_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else begin
            row_nxt = row_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_high) begin
          state_nxt = SCAN;
          row_nxt   = row_idx + 2'd1;
          dwell_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          key_nxt   = key_code(row_idx, col_idx);
          valid_nxt = 1'b1;
          held_nxt  = 1'b1;
          state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_nxt   = '0;
`endif
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        // Only the latched column matters here; everything else is locked out.
        if (col_high) begin
          deb_nxt   = '0;
          state_nxt = RELEASE;
`ifdef KEYPAD_REPEAT_EN
          rep_nxt   = '0;
        end else if (rep_cnt == REP_LAST) begin
          valid_nxt = 1'b1;
          rep_nxt   = '0;
        end else begin
          rep_nxt = rep_cnt + 1'b1;
`endif
        end
      end
      default: begin
        if (!col_high) begin
          state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_nxt   = '0;
`endif
        end else if (deb_cnt == DEB_LAST) begin
          held_nxt  = 1'b0;
          state_nxt = SCAN;
          row_nxt   = row_idx + 2'd1;
          dwell_nxt = '0;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      row_idx   <= '0;
      col_idx   <= '0;
      dwell     <= '0;
      deb_cnt   <= '0;
      rows      <= 4'b1110;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      row_idx   <= row_nxt;
      col_idx   <= col_nxt;
      dwell     <= dwell_nxt;
      deb_cnt   <= deb_nxt;
      rows      <= ~(4'b0001 << row_nxt);
      key       <= key_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_nxt;
`endif
    end
  end

endmodule
